// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60Hz raster timing generator with pixel-rate prescaler
// Optional frame_tick output enabled by VGA_FRAME_TICK_EN.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
        $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    // With CLK_DIV=1 DIV_LAST is 0, so div_cnt stays 0 and p_tick is constantly 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_next = h_count + 10'd1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end
    end

    // Syncs load the decode of the upcoming position so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else if (p_tick) begin
            h_count <= h_next;
            v_count <= v_next;
            hsync   <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync   <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        end
    end

    assign pixel_x  = h_count;
    assign pixel_y  = v_count;
    assign video_on = (h_count < H_DISP) && (v_count < V_DISP);

`ifdef VGA_FRAME_TICK_EN
    assign frame_tick = p_tick && (h_count == H_LAST) && (v_count == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized-reset bench for vga_sync_gen against an arithmetic timing model
module tb_vga_sync_gen;

    localparam int S_CD = 3;
    localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME_CLKS = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB) * S_CD;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       p_tick0, video0, hsync0, vsync0, ft0;
    logic [9:0] x0, y0;
    logic       p_tick1, video1, hsync1, vsync1, ft1;
    logic [9:0] x1, y1;

    int total = 0;
    int bad = 0;

    longint n = 0;
    logic   valid = 1'b0;
    logic   phase_a = 1'b0;
    int     hlow = 0, hfirst = -1, vlow = 0, fcnt = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_def (
        .clk(clk), .reset(reset), .p_tick(p_tick0), .pixel_x(x0), .pixel_y(y0),
        .video_on(video0), .hsync(hsync0), .vsync(vsync0)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft0)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(S_CD), .H_DISPLAY(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_DISPLAY(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk(clk), .reset(reset), .p_tick(p_tick1), .pixel_x(x1), .pixel_y(y1),
        .video_on(video1), .hsync(hsync1), .vsync(vsync1)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft1)
`endif
    );

`ifndef VGA_FRAME_TICK_EN
    assign ft0 = 1'b0;
    assign ft1 = 1'b0;
`endif

    // Position follows directly from the number of clocks since reset.
    function automatic logic [24:0] model(longint cnt, int cd, int hd, int hf, int hsw, int hb,
                                          int vd, int vf, int vsw, int vb);
        longint p;
        int ht, vt, x, y;
        logic t, von, hs, vs, ft;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        p   = cnt / cd;
        x   = int'(p % ht);
        y   = int'((p / ht) % vt);
        t   = (cnt % cd) == cd - 1;
        von = (x < hd) && (y < vd);
        hs  = !(x >= hd + hf && x < hd + hf + hsw);
        vs  = !(y >= vd + vf && y < vd + vf + vsw);
`ifdef VGA_FRAME_TICK_EN
        ft  = t && (x == ht - 1) && (y == vt - 1);
`else
        ft  = 1'b0;
`endif
        return {t, 10'(x), 10'(y), von, hs, vs, ft};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h n=%0d t=%0t", nm, act, exp, n, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            n     <= 0;
            valid <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("def_outputs", {7'd0, p_tick0, x0, y0, video0, hsync0, vsync0, ft0},
                {7'd0, model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
            chk("small_outputs", {7'd0, p_tick1, x1, y1, video1, hsync1, vsync1, ft1},
                {7'd0, model(n, S_CD, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB)});
            if (n == 0)
                chk("def_reset_state", {p_tick0, x0, y0, video0, hsync0, vsync0, ft0},
                    {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
            if (n == 2) chk("def_no_tick_clk2", {31'd0, p_tick0}, 32'd0);
            if (n == 3) chk("def_tick_clk3", {31'd0, p_tick0}, 32'd1);
            if (n == 4) chk("def_x_after_tick", {22'd0, x0}, 32'd1);
            if (n == 639 * 4) chk("def_video_639_0", {31'd0, video0}, 32'd1);
            if (n == 640 * 4) chk("def_video_640_0", {31'd0, video0}, 32'd0);
            if (n == 800 * 4) chk("def_line_wrap", {12'd0, x0, y0}, {12'd0, 10'd0, 10'd1});
            if (phase_a) begin
                if (n < 3200 && p_tick0 && !hsync0) begin
                    if (hlow == 0) hfirst = int'(x0);
                    hlow++;
                end
                if (n < S_FRAME_CLKS && p_tick1 && !vsync1) vlow++;
                if (ft1) fcnt++;
            end
        end
    end

    initial begin
        bit found;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        phase_a = 1'b1;
        repeat (3 * S_FRAME_CLKS + 10) @(posedge clk);
        #1 phase_a = 1'b0;
        chk("hsync_low_ticks", hlow, 96);
        chk("hsync_first_x", hfirst, 656);
        chk("vsync_low_ticks_small", vlow, S_VS * (S_HD + S_HF + S_HS + S_HB));
`ifdef VGA_FRAME_TICK_EN
        chk("frame_ticks_3_frames", fcnt, 3);
`endif

        // Reset coinciding with a pixel tick inside the hsync pulse.
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (p_tick1 && x1 == 10'd25 && y1 == 10'd10) found = 1'b1;
        end
        chk("find_25_10", {31'd0, found}, 32'd1);
        if (found) begin
            chk("pre_reset_hsync_low", {31'd0, hsync1}, 32'd0);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("mid_frame_reset", {11'd0, p_tick1, x1, y1, hsync1, vsync1},
                {11'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1});
        end

        for (int k = 0; k < 15; k++) begin
            repeat ($urandom_range(1, 2500)) @(posedge clk);
            #1 reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 reset = 1'b0;
        end
        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
